down_counter: RTL and testbench

- Loadable down-counter/timer: the counterpart of the team's up counter.
- Counts down from a loaded value to zero under a count-enable, then flags terminal count.
- Holds a done flag until acknowledged.
- Used as a one-shot delay or period timer beside the up counter in the same datapath.

---
 rtl/down_counter.sv | 119 +++++++++++
 tb/tb_down_counter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/down_counter.sv
// Loadable down-counter/timer: counts a loaded value down to zero, pulses tc and holds done until ack.
// Define DOWN_COUNTER_AUTO_RELOAD_EN for free-running period mode (reload on terminal count instead of DONE).
module down_counter #(
  parameter int unsigned     W = 8,
  parameter logic [W-1:0]    I = 8'hFF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         c_down,
  input  logic         ack,
  output logic [W-1:0] q,
  output logic         busy,
  output logic         tc,
  output logic         done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   count_q, count_d;
  logic           tc_q, tc_d;
  logic           busy_q;
  logic           done_q;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [W-1:0]   reload_q, reload_d;
`endif

  // NOTE: every next-state signal gets a default first so this block can never infer a latch.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    tc_d    = 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif

    if (clr) begin
      state_d = S_IDLE;
      count_d = I;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = '0;
`endif
    end else if (load) begin
      // A zero load finishes immediately so the timer never runs a zero-length period.
      count_d = load_val;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_d = load_val;
`endif
      if (load_val == '0) begin
        state_d = S_DONE;
        tc_d    = 1'b1;
      end else begin
        state_d = S_RUN;
      end
    end else begin
      unique case (state_q)
        S_DONE: begin
          if (ack) begin
            state_d = S_IDLE;
            count_d = I;
          end
        end
        S_RUN: begin
          if (c_down) begin
            if (count_q == W'(1)) begin
              tc_d = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
              count_d = reload_q;
`else
              count_d = '0;
              state_d = S_DONE;
`endif
            end else begin
              count_d = count_q - 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= I;
      tc_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      busy_q  <= (state_d == S_RUN);
      done_q  <= (state_d == S_DONE);
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign q    = count_q;
  assign busy = busy_q;
  assign tc   = tc_q;
  assign done = done_q;

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: a behavioural model checked every cycle plus directed literal checks.
// Honours DOWN_COUNTER_AUTO_RELOAD_EN to select one-shot or period-timer expectations.
module tb_down_counter;

  localparam int unsigned  W = 8;
  localparam logic [W-1:0] I = 8'hFF;

  logic         clk = 1'b0;
  logic         rst, clr, load, c_down, ack;
  logic [W-1:0] load_val;
  logic [W-1:0] q;
  logic         busy, tc, done;

  int checks   = 0;
  int failures = 0;

  down_counter #(.W(W), .I(I)) dut (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .c_down   (c_down),
    .ack      (ack),
    .q        (q),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a remaining-count plus running/finished flags, updated from the rules at each edge.
  int unsigned m_count, m_period;
  bit          m_running, m_finished, m_pulse;
  bit          model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst || clr) begin
      m_count    = I;
      m_period   = 0;
      m_running  = 0;
      m_finished = 0;
      m_pulse    = 0;
      model_valid = 1'b1;
    end else begin
      m_pulse = 0;
      if (load) begin
        m_count  = load_val;
        m_period = load_val;
        m_running  = (load_val != 0);
        m_finished = (load_val == 0);
        m_pulse    = (load_val == 0);
      end else if (m_finished && ack) begin
        m_finished = 0;
        m_count    = I;
      end else if (m_running && c_down) begin
        if (m_count == 1) begin
          m_pulse = 1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
          m_count = m_period;
`else
          m_count    = 0;
          m_running  = 0;
          m_finished = 1;
`endif
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      check("model_q",    32'(q),    32'(m_count));
      check("model_busy", 32'(busy), 32'(m_running));
      check("model_tc",   32'(tc),   32'(m_pulse));
      check("model_done", 32'(done), 32'(m_finished));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; c_down = 1'b0; ack = 1'b0; load_val = '0;

    // Reset and idle hold
    repeat (2) tick();
    rst = 1'b0;
    check("reset_q", 32'(q), 32'hFF);
    check("reset_flags", {29'd0, busy, tc, done}, 32'd0);
    repeat (3) begin
      tick();
      check("idle_hold_q", 32'(q), 32'hFF);
      check("idle_hold_flags", {29'd0, busy, tc, done}, 32'd0);
    end

`ifndef DOWN_COUNTER_AUTO_RELOAD_EN
    // Basic count from 5
    do_load(8'd5);
    check("basic_load_q", 32'(q), 32'd5);
    check("basic_load_busy", 32'(busy), 32'd1);
    c_down = 1'b1;
    for (int v = 4; v >= 0; v--) begin
      tick();
      check("basic_q", 32'(q), 32'(v));
      check("basic_tc", 32'(tc), (v == 0) ? 32'd1 : 32'd0);
    end
    check("basic_done", {30'd0, busy, done}, 32'b01);
    repeat (4) begin
      tick();
      check("basic_hold_q", 32'(q), 32'd0);
      check("basic_hold_tc_done", {30'd0, tc, done}, 32'b01);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("basic_ack_q", 32'(q), 32'hFF);
    check("basic_ack_done", 32'(done), 32'd0);
    c_down = 1'b0;

    // Gated enable from 4
    do_load(8'd4);
    check("gated_load_q", 32'(q), 32'd4);
    begin
      logic [5:0]  pat;
      logic [23:0] exp_seq;
      pat     = 6'b101011;
      exp_seq = {4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3};
      for (int k = 0; k < 6; k++) begin
        c_down = pat[k];
        tick();
        check("gated_q", 32'(q), 32'(exp_seq[k*4 +: 4]));
        check("gated_tc", 32'(tc), (k == 5) ? 32'd1 : 32'd0);
      end
    end
    c_down = 1'b0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
`endif

    // clr and load together mid-run: clr wins
    do_load(8'd5);
    c_down = 1'b1;
    repeat (2) tick();
    c_down = 1'b0;
    check("coll_pre_q", 32'(q), 32'd3);
    clr = 1'b1; load = 1'b1; load_val = 8'd9;
    tick();
    clr = 1'b0; load = 1'b0;
    check("coll_clr_q", 32'(q), 32'hFF);
    check("coll_clr_busy", 32'(busy), 32'd0);

    // load alone mid-run restarts
    do_load(8'd5);
    c_down = 1'b1;
    repeat (2) tick();
    c_down = 1'b0;
    do_load(8'd9);
    check("coll_load_q", 32'(q), 32'd9);
    check("coll_load_busy", 32'(busy), 32'd1);

    // Zero load goes straight to DONE
    do_load(8'd0);
    check("zero_q", 32'(q), 32'd0);
    check("zero_tc_done", {29'd0, busy, tc, done}, 32'b011);
    tick();
    check("zero_tc_clear", 32'(tc), 32'd0);

    // load and ack together in DONE: load wins
    load = 1'b1; ack = 1'b1; load_val = 8'd2;
    tick();
    load = 1'b0; ack = 1'b0;
    check("done_load_ack_q", 32'(q), 32'd2);
    check("done_load_ack_flags", {30'd0, busy, done}, 32'b10);

    // Reset mid-run
    do_load(8'd7);
    check("rst_pre_q", 32'(q), 32'd7);
    rst = 1'b1; c_down = 1'b1;
    tick();
    rst = 1'b0; c_down = 1'b0;
    check("rst_mid_q", 32'(q), 32'hFF);
    check("rst_mid_flags", {29'd0, busy, tc, done}, 32'd0);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // Period mode: 3,2,1 repeating with a tc on each reload
    begin
      int tc_seen;
      logic [17:0] exp_seq;
      tc_seen = 0;
      exp_seq = {2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
      load = 1'b1; load_val = 8'd3; c_down = 1'b1;
      for (int k = 0; k < 9; k++) begin
        tick();
        load = 1'b0;
        check("reload_q", 32'(q), 32'(exp_seq[k*2 +: 2]));
        check("reload_busy_done", {30'd0, busy, done}, 32'b10);
        if (tc) tc_seen++;
      end
      check("reload_tc_count", 32'(tc_seen), 32'd2);
      tick();
      check("reload_q_wrap", 32'(q), 32'd3);
      check("reload_tc_third", 32'(tc), 32'd1);
      c_down = 1'b0;
    end
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
